// File: rtl/umi_regfile_pkg.sv
// Shared constants and helpers for the UMI register file and its atomic ALU.
package umi_regfile_pkg;

    localparam int unsigned REG_BYTES = 4;

    localparam logic [7:0] ATYPE_ADD  = 8'h00;
    localparam logic [7:0] ATYPE_AND  = 8'h01;
    localparam logic [7:0] ATYPE_OR   = 8'h02;
    localparam logic [7:0] ATYPE_XOR  = 8'h03;
    localparam logic [7:0] ATYPE_MAX  = 8'h04;
    localparam logic [7:0] ATYPE_MIN  = 8'h05;
    localparam logic [7:0] ATYPE_MAXU = 8'h06;
    localparam logic [7:0] ATYPE_MINU = 8'h07;
    localparam logic [7:0] ATYPE_SWAP = 8'h08;

    function automatic logic [63:0] width_mask(input logic [1:0] size);
        case (size)
            2'd0:    return 64'h0000_0000_0000_00ff;
            2'd1:    return 64'h0000_0000_0000_ffff;
            2'd2:    return 64'h0000_0000_ffff_ffff;
            default: return 64'hffff_ffff_ffff_ffff;
        endcase
    endfunction

    // Sign-extend the low (8 << size) bits of v to 64 bits.
    function automatic logic [63:0] sext(input logic [63:0] v, input logic [1:0] size);
        case (size)
            2'd0:    return {{56{v[7]}}, v[7:0]};
            2'd1:    return {{48{v[15]}}, v[15:0]};
            2'd2:    return {{32{v[31]}}, v[31:0]};
            default: return v;
        endcase
    endfunction

endpackage

// File: rtl/umi_atomic_alu.sv
// Combinational atomic operation f(old, op) at operand width 8 << size_i.
module umi_atomic_alu
    import umi_regfile_pkg::*;
(
    input  logic [63:0] old_i,
    input  logic [63:0] op_i,
    input  logic [7:0]  atype_i,
    input  logic [1:0]  size_i,
    output logic [63:0] result_o,
    output logic        valid_o
);

    logic [63:0] mask;
    logic [63:0] a;
    logic [63:0] b;
    logic        lt_s;
    logic        lt_u;

    always_comb begin
        mask     = width_mask(size_i);
        a        = old_i & mask;
        b        = op_i & mask;
        lt_s     = $signed(sext(a, size_i)) < $signed(sext(b, size_i));
        lt_u     = a < b;
        valid_o  = 1'b1;
        result_o = '0;
        case (atype_i)
            ATYPE_ADD:  result_o = (a + b) & mask;
            ATYPE_AND:  result_o = a & b;
            ATYPE_OR:   result_o = a | b;
            ATYPE_XOR:  result_o = a ^ b;
            ATYPE_MAX:  result_o = lt_s ? b : a;
            ATYPE_MIN:  result_o = lt_s ? a : b;
            ATYPE_MAXU: result_o = lt_u ? b : a;
            ATYPE_MINU: result_o = lt_u ? a : b;
            ATYPE_SWAP: result_o = b;
            default:    valid_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/umi_regfile.sv
// Byte-addressable register file behind the UMI endpoint's local memory interface.
module umi_regfile
    import umi_regfile_pkg::*;
#(
    parameter int unsigned     DW   = 256,
    parameter int unsigned     AW   = 64,
    parameter int unsigned     NREG = 16,
    parameter logic [AW-1:0]   BASE = '0
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic [AW-1:0]        loc_addr,
    input  logic                 loc_write,
    input  logic                 loc_read,
    input  logic                 loc_atomic,
    input  logic [7:0]           loc_opcode,
    input  logic [2:0]           loc_size,
    input  logic [7:0]           loc_len,
    input  logic [7:0]           loc_atype,
    input  logic [DW-1:0]        loc_wrdata,
    output logic [DW-1:0]        loc_rddata,
    output logic                 loc_ready,
    output logic                 loc_err,
    output logic [NREG*32-1:0]   regs_out
);

    localparam int unsigned NBYTES = NREG * REG_BYTES;
    localparam int unsigned IW     = $clog2(NBYTES);
    localparam int unsigned DB     = DW / 8;

    logic [7:0]    mem_q [NBYTES];
    logic [7:0]    mem_d [NBYTES];
    logic [DW-1:0] rddata_q, rddata_d;
    logic          err_q, err_d;
    logic          ready_q;

    logic [AW-1:0] off;
    logic [AW+8:0] nbytes;
    logic          in_range;
    logic          is_atomic, is_write, is_read, any_req;
    logic [DW-1:0] rd_win;
    logic [DW-1:0] wr_bus;
    logic [63:0]   alu_result;
    logic          alu_valid;
    logic          atomic_ok;
    logic          do_wr;
    logic [IW-1:0] idx;
    logic          unused_opcode;

    assign unused_opcode = ^loc_opcode;

    // Strobes are exclusive in normal use; this ordering only matters if that is violated.
    assign is_atomic = loc_atomic;
    assign is_write  = loc_write & ~loc_atomic;
    assign is_read   = loc_read & ~loc_atomic & ~loc_write;
    assign any_req   = loc_atomic | loc_write | loc_read;

    // Wide arithmetic so a high wrapped offset can never alias back into range.
    always_comb begin
        off      = loc_addr - BASE;
        nbytes   = ({{(AW + 1){1'b0}}, loc_len} + (AW + 9)'(1)) << loc_size;
        in_range = ({9'd0, off} + nbytes) <= (AW + 9)'(NBYTES);
    end

    always_comb begin
        rd_win = '0;
        for (int b = 0; b < DB; b++) begin
            idx = off[IW-1:0] + IW'(b);
            if ((AW + 9)'(b) < nbytes) begin
                rd_win[8*b +: 8] = mem_q[idx];
            end
        end
    end

    umi_atomic_alu u_alu (
        .old_i    (rd_win[63:0]),
        .op_i     (loc_wrdata[63:0]),
        .atype_i  (loc_atype),
        .size_i   (loc_size[1:0]),
        .result_o (alu_result),
        .valid_o  (alu_valid)
    );

    assign atomic_ok = alu_valid & ~loc_size[2] & (loc_len == 8'd0);
    assign do_wr     = in_range & (is_write | (is_atomic & atomic_ok));

    always_comb begin
        wr_bus = loc_wrdata;
        if (is_atomic) begin
            wr_bus[63:0] = alu_result;
        end
        mem_d = mem_q;
        if (do_wr) begin
            for (int b = 0; b < DB; b++) begin
                if ((AW + 9)'(b) < nbytes) begin
                    mem_d[off[IW-1:0] + IW'(b)] = wr_bus[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        rddata_d = rddata_q;
        if (is_read || is_atomic) begin
            rddata_d = in_range ? rd_win : '0;
        end
        err_d = err_q | (any_req & ~in_range);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i < NBYTES; i++) begin
                mem_q[i] <= '0;
            end
            rddata_q <= '0;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            rddata_q <= rddata_d;
            err_q    <= err_d;
            ready_q  <= 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            regs_out[32*i +: 32] = {mem_q[4*i+3], mem_q[4*i+2], mem_q[4*i+1], mem_q[4*i]};
        end
    end

    assign loc_rddata = rddata_q;
    assign loc_err    = err_q;
    assign loc_ready  = ready_q;

endmodule

// File: tb/tb_umi_regfile.sv
// Directed bench for umi_regfile: scoreboard queue of expected read/atomic data.
module tb_umi_regfile;

    localparam int unsigned   DW   = 256;
    localparam int unsigned   AW   = 64;
    localparam int unsigned   NREG = 16;
    localparam logic [63:0]   BASE = 64'h100;

    logic                clk;
    logic                nreset;
    logic [AW-1:0]       loc_addr;
    logic                loc_write, loc_read, loc_atomic;
    logic [7:0]          loc_opcode;
    logic [2:0]          loc_size;
    logic [7:0]          loc_len;
    logic [7:0]          loc_atype;
    logic [DW-1:0]       loc_wrdata;
    logic [DW-1:0]       loc_rddata;
    logic                loc_ready;
    logic                loc_err;
    logic [NREG*32-1:0]  regs_out;

    int checks;
    int errors;
    logic [DW-1:0]      exp_q [$];
    logic [NREG*32-1:0] exp_regs;

    umi_regfile #(
        .DW   (DW),
        .AW   (AW),
        .NREG (NREG),
        .BASE (BASE)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .loc_addr   (loc_addr),
        .loc_write  (loc_write),
        .loc_read   (loc_read),
        .loc_atomic (loc_atomic),
        .loc_opcode (loc_opcode),
        .loc_size   (loc_size),
        .loc_len    (loc_len),
        .loc_atype  (loc_atype),
        .loc_wrdata (loc_wrdata),
        .loc_rddata (loc_rddata),
        .loc_ready  (loc_ready),
        .loc_err    (loc_err),
        .regs_out   (regs_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic w, input logic r, input logic a, input logic [AW-1:0] addr,
                         input logic [2:0] size, input logic [7:0] len, input logic [7:0] atype,
                         input logic [DW-1:0] data, input logic [DW-1:0] exp);
        loc_write  = w;
        loc_read   = r;
        loc_atomic = a;
        loc_addr   = addr;
        loc_size   = size;
        loc_len    = len;
        loc_atype  = atype;
        loc_wrdata = data;
        if (r || a) exp_q.push_back(exp);
        @(posedge clk);
        @(negedge clk);
        loc_write  = 1'b0;
        loc_read   = 1'b0;
        loc_atomic = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [2:0] size, input logic [7:0] len,
                      input logic [DW-1:0] data);
        drive(1'b1, 1'b0, 1'b0, addr, size, len, 8'h00, data, '0);
    endtask

    task automatic rd(input logic [AW-1:0] addr, input logic [2:0] size, input logic [7:0] len,
                      input logic [DW-1:0] exp);
        drive(1'b0, 1'b1, 1'b0, addr, size, len, 8'h00, '0, exp);
    endtask

    task automatic at(input logic [AW-1:0] addr, input logic [2:0] size, input logic [7:0] atype,
                      input logic [DW-1:0] op, input logic [DW-1:0] exp);
        drive(1'b0, 1'b0, 1'b1, addr, size, 8'd0, atype, op, exp);
    endtask

    // Read/atomic data is due exactly one edge after acceptance.
    always @(posedge clk) begin
        if (nreset && (loc_read || loc_atomic)) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rddata: got %h want <no pending expectation>", loc_rddata);
            end else begin
                check("rddata", 512'(loc_rddata), 512'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        exp_regs   = '0;
        nreset     = 1'b0;
        loc_addr   = '0;
        loc_write  = 1'b0;
        loc_read   = 1'b0;
        loc_atomic = 1'b0;
        loc_opcode = 8'h00;
        loc_size   = 3'd0;
        loc_len    = 8'd0;
        loc_atype  = 8'd0;
        loc_wrdata = '0;

        repeat (2) @(negedge clk);
        check("reset_ready", 512'(loc_ready), 512'd0);
        check("reset_regs", 512'(regs_out), 512'd0);
        check("reset_err", 512'(loc_err), 512'd0);
        check("reset_rddata", 512'(loc_rddata), 512'd0);
        nreset = 1'b1;
        #1;
        check("ready_before_edge", 512'(loc_ready), 512'd0);
        @(posedge clk);
        @(negedge clk);
        check("ready_after_edge", 512'(loc_ready), 512'd1);

        wr(BASE + 4, 3'd2, 8'd1, 256'h22221111_DEADBEEF);
        exp_regs[63:32] = 32'hDEADBEEF;
        exp_regs[95:64] = 32'h22221111;
        check("regs_wr_len1", 512'(regs_out), 512'(exp_regs));
        rd(BASE + 4, 3'd2, 8'd1, 256'h22221111_DEADBEEF);

        wr(BASE + 5, 3'd0, 8'd0, 256'hAB);
        exp_regs[63:32] = 32'hDEADABEF;
        check("regs_byte_wr", 512'(regs_out), 512'(exp_regs));

        wr(BASE, 3'd2, 8'd0, 256'h7FFFFFFF);
        at(BASE, 3'd2, 8'h00, 256'd1, 256'h7FFFFFFF);
        exp_regs[31:0] = 32'h80000000;
        check("regs_add", 512'(regs_out), 512'(exp_regs));
        at(BASE, 3'd2, 8'h04, 256'd5, 256'h80000000);
        exp_regs[31:0] = 32'd5;
        check("regs_max", 512'(regs_out), 512'(exp_regs));
        at(BASE, 3'd2, 8'h06, 256'd5, 256'd5);
        check("regs_maxu", 512'(regs_out), 512'(exp_regs));
        at(BASE, 3'd2, 8'h08, 256'h1234, 256'd5);
        exp_regs[31:0] = 32'h1234;
        check("regs_swap", 512'(regs_out), 512'(exp_regs));
        // 8-bit signed: 0x80 (-128) is below 0x34.
        at(BASE, 3'd0, 8'h05, 256'h80, 256'h34);
        exp_regs[31:0] = 32'h1280;
        check("regs_min8", 512'(regs_out), 512'(exp_regs));
        at(BASE, 3'd2, 8'h20, 256'hFFFF, 256'h1280);
        check("regs_unknown_atype", 512'(regs_out), 512'(exp_regs));
        at(BASE + 4, 3'd3, 8'h03, 256'hFFFFFFFF_00000000, 256'h22221111_DEADABEF);
        exp_regs[95:64] = 32'hDDDDEEEE;
        check("regs_xor64", 512'(regs_out), 512'(exp_regs));

        wr(BASE + 60, 3'd2, 8'd0, 256'h55AA);
        exp_regs[511:480] = 32'h55AA;
        rd(BASE + 60, 3'd2, 8'd0, 256'h55AA);
        check("err_in_range_top", 512'(loc_err), 512'd0);

        rd(BASE + 62, 3'd2, 8'd0, 256'd0);
        check("err_set", 512'(loc_err), 512'd1);
        wr(BASE - 4, 3'd2, 8'd0, 256'hFFFFFFFF);
        check("regs_oob_write", 512'(regs_out), 512'(exp_regs));
        check("err_sticky", 512'(loc_err), 512'd1);

        wr(BASE + 12, 3'd2, 8'd0, 256'hCAFEF00D);
        rd(BASE + 12, 3'd2, 8'd0, 256'hCAFEF00D);
        exp_regs[127:96] = 32'hCAFEF00D;
        wr(BASE + 8, 3'd1, 8'd0, 256'h7777);
        exp_regs[79:64] = 16'h7777;
        check("rddata_hold", 512'(loc_rddata), 512'h CAFEF00D);
        check("regs_final", 512'(regs_out), 512'(exp_regs));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 512'(exp_q.size()), 512'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
